// File: rtl/camera_pkg.sv
// Shared types, widths and pixel packing for the camera pixel-domain pipeline.
package camera_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURING, DONE} capture_state_t;

    localparam int PIXEL_W = 10;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int COUNT_W = 11;

    function automatic logic [DATA_W-1:0] rgb332(input logic [PIXEL_W-1:0] r,
                                                 input logic [PIXEL_W-1:0] g,
                                                 input logic [PIXEL_W-1:0] b);
        return {r[9:7], g[9:7], b[9:8]};
    endfunction

endpackage

// File: rtl/image_buffer_writer_if.sv
// Write port into image_buffer: one strobe per byte with address and data.
interface image_buffer_writer_if;
    import camera_pkg::*;

    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;

    modport master (output write_address, write_data, write_enable);
    modport slave  (input  write_address, write_data, write_enable);

endinterface

// File: rtl/image_buffer_writer.sv
// Captures one cropped frame per request, packs pixels to RGB332 and writes them
// into image_buffer, flagging buffer overflow and line/frame size mismatches.
module image_buffer_writer
    import camera_pkg::*;
#(
    parameter int X_RESOLUTION = 200,
    parameter int Y_RESOLUTION = 200,
    parameter int BUFFER_DEPTH = 65536
) (
    input  logic                  clock_pixel_in,
    input  logic                  reset_pixel_n_in,
    input  logic                  capture_start_in,
    input  logic [PIXEL_W-1:0]    pixel_red_data_in,
    input  logic [PIXEL_W-1:0]    pixel_green_data_in,
    input  logic [PIXEL_W-1:0]    pixel_blue_data_in,
    input  logic                  line_valid_in,
    input  logic                  frame_valid_in,
    image_buffer_writer_if.master write_bus,
    output logic                  capture_in_progress_out,
    output logic                  capture_done_out,
    output logic [ADDR_W-1:0]     bytes_written_out,
    output logic                  overflow_out,
    output logic                  size_error_out
);

    localparam logic [ADDR_W:0]    LAST_ADDR = (ADDR_W + 1)'(BUFFER_DEPTH - 1);
    localparam logic [COUNT_W-1:0] X_COUNT   = COUNT_W'(X_RESOLUTION);
    localparam logic [COUNT_W-1:0] Y_COUNT   = COUNT_W'(Y_RESOLUTION);

    capture_state_t     state;
    logic [1:0]         valid_prev;   // {frame_valid, line_valid} last cycle
    logic [ADDR_W-1:0]  address;
    logic               buffer_full;
    logic [COUNT_W-1:0] pixel_count;
    logic [COUNT_W-1:0] line_count;
    logic [COUNT_W-1:0] line_total;
    logic               fv_rise, fv_fall, lv_fall, line_end, take_pixel;

    assign fv_rise    = frame_valid_in & ~valid_prev[1];
    assign fv_fall    = ~frame_valid_in & valid_prev[1];
    assign lv_fall    = ~line_valid_in & valid_prev[0];
    // A frame that closes with line_valid still high ends that line too.
    assign line_end   = (state == CAPTURING) & (lv_fall | (fv_fall & line_valid_in));
    assign take_pixel = frame_valid_in & line_valid_in &
                        ((state == CAPTURING) | ((state == ARMED) & fv_rise));
    assign line_total = (line_end && line_count != '1) ? line_count + 1'b1 : line_count;

    always_ff @(posedge clock_pixel_in) begin
        if (!reset_pixel_n_in) begin
            state                   <= IDLE;
            valid_prev              <= '0;
            address                 <= '0;
            buffer_full             <= 1'b0;
            pixel_count             <= '0;
            line_count              <= '0;
            write_bus.write_address <= '0;
            write_bus.write_data    <= '0;
            write_bus.write_enable  <= 1'b0;
            capture_in_progress_out <= 1'b0;
            capture_done_out        <= 1'b0;
            bytes_written_out       <= '0;
            overflow_out            <= 1'b0;
            size_error_out          <= 1'b0;
        end else begin
            valid_prev             <= {frame_valid_in, line_valid_in};
            write_bus.write_enable <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (capture_start_in) begin
                        state                   <= ARMED;
                        capture_in_progress_out <= 1'b1;
                        capture_done_out        <= 1'b0;
                        bytes_written_out       <= '0;
                        overflow_out            <= 1'b0;
                        size_error_out          <= 1'b0;
                        address                 <= '0;
                        buffer_full             <= 1'b0;
                        pixel_count             <= '0;
                        line_count              <= '0;
                    end
                end
                ARMED: begin
                    if (fv_rise) state <= CAPTURING;
                end
                CAPTURING: begin
                    if (line_end) begin
                        pixel_count <= '0;
                        line_count  <= line_total;
                        if (pixel_count != X_COUNT) size_error_out <= 1'b1;
                    end
                    if (fv_fall) begin
                        state                   <= DONE;
                        capture_in_progress_out <= 1'b0;
                        capture_done_out        <= 1'b1;
                        if (line_total != Y_COUNT) size_error_out <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // take_pixel and line_end are mutually exclusive (valid high vs. falling).
            if (take_pixel) begin
                if (pixel_count != '1) pixel_count <= pixel_count + 1'b1;
                if (buffer_full) begin
                    overflow_out <= 1'b1;
                end else begin
                    write_bus.write_enable  <= 1'b1;
                    write_bus.write_address <= address;
                    write_bus.write_data    <= rgb332(pixel_red_data_in,
                                                      pixel_green_data_in,
                                                      pixel_blue_data_in);
                    if ({1'b0, address} == LAST_ADDR) buffer_full <= 1'b1;
                    else                              address     <= address + 1'b1;
                    if (bytes_written_out != '1) bytes_written_out <= bytes_written_out + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_buffer_writer.sv
// Directed bench: full-size capture, overflow on a shallow buffer, size errors on a
// small-resolution instance, mid-frame arming and reset mid-capture.
module tb_image_buffer_writer;
    import camera_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_big = 1'b0;
    logic start_sm = 1'b0;
    logic [9:0] r = '0, g = '0, b = '0;
    logic lv = 1'b0, fv = 1'b0;

    logic        in_prog [3];
    logic        done    [3];
    logic [15:0] bytes_w [3];
    logic        ovf     [3];
    logic        serr    [3];
    logic [44:0] out_vec [3];

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    image_buffer_writer_if bus0();
    image_buffer_writer_if bus1();
    image_buffer_writer_if bus2();

    image_buffer_writer #(.X_RESOLUTION(200), .Y_RESOLUTION(200), .BUFFER_DEPTH(65536)) dut (
        .clock_pixel_in(clk), .reset_pixel_n_in(rst_n), .capture_start_in(start_big),
        .pixel_red_data_in(r), .pixel_green_data_in(g), .pixel_blue_data_in(b),
        .line_valid_in(lv), .frame_valid_in(fv), .write_bus(bus0),
        .capture_in_progress_out(in_prog[0]), .capture_done_out(done[0]),
        .bytes_written_out(bytes_w[0]), .overflow_out(ovf[0]), .size_error_out(serr[0]));

    image_buffer_writer #(.X_RESOLUTION(200), .Y_RESOLUTION(200), .BUFFER_DEPTH(1000)) dut_ovf (
        .clock_pixel_in(clk), .reset_pixel_n_in(rst_n), .capture_start_in(start_big),
        .pixel_red_data_in(r), .pixel_green_data_in(g), .pixel_blue_data_in(b),
        .line_valid_in(lv), .frame_valid_in(fv), .write_bus(bus1),
        .capture_in_progress_out(in_prog[1]), .capture_done_out(done[1]),
        .bytes_written_out(bytes_w[1]), .overflow_out(ovf[1]), .size_error_out(serr[1]));

    image_buffer_writer #(.X_RESOLUTION(8), .Y_RESOLUTION(6), .BUFFER_DEPTH(65536)) dut_sm (
        .clock_pixel_in(clk), .reset_pixel_n_in(rst_n), .capture_start_in(start_sm),
        .pixel_red_data_in(r), .pixel_green_data_in(g), .pixel_blue_data_in(b),
        .line_valid_in(lv), .frame_valid_in(fv), .write_bus(bus2),
        .capture_in_progress_out(in_prog[2]), .capture_done_out(done[2]),
        .bytes_written_out(bytes_w[2]), .overflow_out(ovf[2]), .size_error_out(serr[2]));

    assign out_vec[0] = {bus0.write_enable, bus0.write_address, bus0.write_data,
                         in_prog[0], done[0], bytes_w[0], ovf[0], serr[0]};
    assign out_vec[1] = {bus1.write_enable, bus1.write_address, bus1.write_data,
                         in_prog[1], done[1], bytes_w[1], ovf[1], serr[1]};
    assign out_vec[2] = {bus2.write_enable, bus2.write_address, bus2.write_data,
                         in_prog[2], done[2], bytes_w[2], ovf[2], serr[2]};

    // Write monitors: counts, first/last address, address sequence and data errors.
    int          wr_cnt   [3];
    int          seq_bad  [3];
    int          data_bad [3];
    logic [15:0] first_a  [3];
    logic [15:0] last_a   [3];
    logic [7:0]  exp_d    [3];
    int epoch = 0;
    int seen_epoch = 0;

    function automatic void mon_step(input int i, input logic we, input logic [15:0] a,
                                     input logic [7:0] d);
        if (we) begin
            if (wr_cnt[i] == 0) first_a[i] = a;
            last_a[i] = a;
            if (a != 16'(wr_cnt[i])) seq_bad[i]++;
            if (d != exp_d[i]) data_bad[i]++;
            wr_cnt[i]++;
        end
    endfunction

    always @(negedge clk) begin
        if (epoch != seen_epoch) begin
            for (int i = 0; i < 3; i++) begin
                wr_cnt[i] = 0; seq_bad[i] = 0; data_bad[i] = 0;
                first_a[i] = '0; last_a[i] = '0;
            end
            seen_epoch = epoch;
        end
        mon_step(0, bus0.write_enable, bus0.write_address, bus0.write_data);
        mon_step(1, bus1.write_enable, bus1.write_address, bus1.write_data);
        mon_step(2, bus2.write_enable, bus2.write_address, bus2.write_data);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // One frame: fv rises with the first pixel, 1-cycle line blanking, 3-cycle frame blanking.
    task automatic drive_frame(input int lines, input int ppl, input int short_line,
                               input bit lv_open_end);
        for (int l = 0; l < lines; l++) begin
            int len = (l == short_line) ? ppl - 1 : ppl;
            for (int p = 0; p < len; p++) begin
                @(negedge clk); fv = 1'b1; lv = 1'b1;
            end
            if (!(l == lines - 1 && lv_open_end)) begin
                @(negedge clk); lv = 1'b0;
            end
        end
        @(negedge clk); fv = 1'b0;
        @(negedge clk); lv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse(input bit big);
        @(negedge clk);
        if (big) start_big = 1'b1; else start_sm = 1'b1;
        @(negedge clk);
        start_big = 1'b0; start_sm = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) exp_d[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_dut", 64'(out_vec[0]), 64'd0);
        chk("rst_ovf", 64'(out_vec[1]), 64'd0);
        chk("rst_sm",  64'(out_vec[2]), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame without any capture request.
        r = 10'h3FF; g = 10'h000; b = 10'h155;
        epoch++;
        drive_frame(6, 8, -1, 1'b0);
        chk("nostart_wr_dut", 64'(wr_cnt[0]), 64'd0);
        chk("nostart_wr_sm",  64'(wr_cnt[2]), 64'd0);
        chk("nostart_out_dut", 64'(out_vec[0]), 64'd0);
        chk("nostart_out_sm",  64'(out_vec[2]), 64'd0);

        // Arm the 200x200 instances in the middle of a frame: that frame is skipped.
        epoch++;
        fork
            drive_frame(6, 8, -1, 1'b0);
            begin repeat (20) @(negedge clk); start_big = 1'b1; @(negedge clk); start_big = 1'b0; end
        join
        chk("midarm_wr",    64'(wr_cnt[0]), 64'd0);
        chk("midarm_armed", 64'({in_prog[0], done[0]}), 64'b10);

        // Full 200x200 frame: captured by dut, overflows the 1000-byte instance.
        exp_d[0] = 8'hE1; exp_d[1] = 8'hE1;
        epoch++;
        drive_frame(200, 200, -1, 1'b0);
        chk("full_wr",     64'(wr_cnt[0]), 64'd40000);
        chk("full_first",  64'(first_a[0]), 64'h0);
        chk("full_last",   64'(last_a[0]), 64'h9C3F);
        chk("full_seq",    64'(seq_bad[0]), 64'd0);
        chk("full_data",   64'(data_bad[0]), 64'd0);
        chk("full_bytes",  64'(bytes_w[0]), 64'h9C40);
        chk("full_status", 64'({in_prog[0], done[0], ovf[0], serr[0]}), 64'b0100);
        chk("ovf_wr",      64'(wr_cnt[1]), 64'd1000);
        chk("ovf_last",    64'(last_a[1]), 64'd999);
        chk("ovf_seq",     64'(seq_bad[1]), 64'd0);
        chk("ovf_bytes",   64'(bytes_w[1]), 64'd1000);
        chk("ovf_status",  64'({in_prog[1], done[1], ovf[1], serr[1]}), 64'b0110);

        // Small instance (8x6): short line, then too many lines, then a clean frame.
        r = 10'h2AA; g = 10'h1FF; b = 10'h300;
        exp_d[2] = 8'hAF;
        pulse(1'b0);
        epoch++;
        drive_frame(6, 8, 2, 1'b0);
        chk("short_line_serr",  64'({done[2], serr[2]}), 64'b11);
        chk("short_line_bytes", 64'(bytes_w[2]), 64'd47);
        pulse(1'b0);
        chk("rearm_clear", 64'({in_prog[2], done[2], serr[2], bytes_w[2]}), {45'd0, 3'b100, 16'd0});
        epoch++;
        drive_frame(7, 8, -1, 1'b0);
        chk("extra_line_serr",  64'({done[2], serr[2]}), 64'b11);
        chk("extra_line_bytes", 64'(bytes_w[2]), 64'd56);
        pulse(1'b0);
        epoch++;
        // Clean frame ending with line_valid still high; a start pulse mid-capture is ignored.
        fork
            drive_frame(6, 8, -1, 1'b1);
            begin repeat (15) @(negedge clk); start_sm = 1'b1; @(negedge clk); start_sm = 1'b0; end
        join
        chk("clean_status", 64'({in_prog[2], done[2], ovf[2], serr[2]}), 64'b0100);
        chk("clean_bytes",  64'(bytes_w[2]), 64'd48);
        chk("clean_wr",     64'(wr_cnt[2]), 64'd48);
        chk("clean_last",   64'(last_a[2]), 64'd47);
        chk("clean_data",   64'(data_bad[2]), 64'd0);

        // Reset asserted at pixel 5000 of a 200x200 capture.
        r = 10'h3FF; g = 10'h000; b = 10'h155;
        pulse(1'b1);
        begin
            int px = 0;
            for (int l = 0; l < 200 && px < 5000; l++) begin
                for (int p = 0; p < 200 && px < 5000; p++) begin
                    @(negedge clk); fv = 1'b1; lv = 1'b1; px++;
                end
                if (px < 5000) begin @(negedge clk); lv = 1'b0; end
            end
        end
        @(negedge clk);
        chk("prerst_we",    64'(bus0.write_enable), 64'd1);
        chk("prerst_bytes", 64'(bytes_w[0]), 64'd5000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_dut", 64'(out_vec[0]), 64'd0);
        chk("midrst_ovf", 64'(out_vec[1]), 64'd0);
        chk("midrst_sm",  64'(out_vec[2]), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_idle", 64'(out_vec[0]), 64'd0);
        fv = 1'b0; lv = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
